dual_issue_scheduler: RTL and testbench
=======================================

Name: dual_issue_scheduler

Overview:
Issue controller for the dual-issue pipeline, sitting between the decode register pair and the two ID/EX registers.
- Each cycle it decides whether decode slot 1, slot 2, both, or neither issue, and drives the fetch/decode stall and per-pipe bubble controls.
- It splits intra-pair dependent or structurally conflicting pairs over two cycles.
- It blocks load-use hazards that forwarding cannot cover.
- It keeps saturating performance counters for splits and load-use stalls.

Parameters:
CNT_W, 16, width of the split and load-use stall counters
MEM_PORTS, 1, data-memory ports; 1 means two memory ops in one pair conflict, 2 disables that check

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
valid1, valid2  input  1  decode slot 1/2 holds a real instruction
rs1, rt1, rd1  input  5  slot 1 source/destination registers (rd = final write register)
rs2, rt2, rd2  input  5  slot 2 source/destination registers
useRs1, useRt1, useRs2, useRt2  input  1  source operand actually read
regWrite1, regWrite2  input  1  slot writes register file
mem1, mem2  input  1  slot is load or store
memReadE1, memReadE2  input  1  EX-stage pipe 1/2 holds a load
writeRegisterE1, writeRegisterE2  input  5  EX-stage pipe 1/2 destination
stallIn  input  1  downstream (memory) stall request
flushD  input  1  branch redirect; kill decode pair
issue1, issue2  output  1  load decode slot into ID/EX pipe 1/2 (0 = insert bubble)
stallF, stallD  output  1  hold PC / hold decode register
splitCount, loadUseCount  output  CNT_W  saturating event counters

Behaviour:
- State register: PAIR (both slots pending) and SECOND (slot 1 already issued, slot 2 pending). Reset → PAIR, counters 0.
- Outputs are combinational from state and inputs (zero latency). While rst is low: issue1 = issue2 = stallF = stallD = 0.
- Hazard definitions:
  - Register 0 never matches.
  - ldHazN (N = 1, 2): a source of slot N with useX set equals writeRegisterEk where memReadEk = 1, for k = 1 or 2.
  - dep (requires valid1 & valid2):
    - RAW: regWrite1 and rd1 equals a used source of slot 2; or
    - WAW: regWrite1 & regWrite2 and rd1 == rd2; or
    - memory conflict: mem1 & mem2 with MEM_PORTS == 1.
- Priority, highest first:
  1. flushD: issue1 = issue2 = 0, stallF = stallD = 0, next state PAIR. Counters unchanged. Flush overrides stallIn.
  2. stallIn: issue1 = issue2 = 0, stallF = stallD = 1, state holds. No counter change.
- In PAIR:
  - valid1 & ldHaz1: no issue, stall both, stay PAIR, loadUseCount += 1.
  - !valid1 & valid2 & ldHaz2: no issue, stall, stay, loadUseCount += 1.
  - valid1 & valid2 & (dep | ldHaz2): issue1 = 1, issue2 = 0, stallF = stallD = 1, go SECOND, splitCount += 1.
  - Otherwise: issue1 = valid1, issue2 = valid2, no stall, stay PAIR.
- In SECOND:
  - ldHaz2: no issue, stall, stay SECOND, loadUseCount += 1.
  - Otherwise: issue1 = 0, issue2 = 1, no stall, go PAIR.
  - Slot 1 is never reissued from SECOND.
- Issue is strictly in order: slot 2 never issues before slot 1.
- Counters saturate at 2^CNT_W - 1 and never wrap. A split and a load-use stall cannot occur in the same cycle.
- Asynchronous reset mid-SECOND: the pending slot 2 is dropped, and the state and counters clear immediately.

Test Plan:
1. Independent pair (rs2 = 3, rd1 = 5, regWrite1 = 1) → issue1 = issue2 = 1, no stall, counters 0.
2. RAW pair (rd1 = 5, rs2 = 5, useRs2 = 1):
   - cycle 0 → issue1 = 1, issue2 = 0, stallF = stallD = 1;
   - cycle 1 → issue2 = 1, stall 0;
   - splitCount = 1.
3. Load-use (memReadE2 = 1, writeRegisterE2 = 7, rt1 = 7, useRt1 = 1) → no issue, stall, loadUseCount = 1. Next cycle with memReadE2 = 0 → both issue.
4. Two memory ops with MEM_PORTS = 1 → split over 2 cycles. With MEM_PORTS = 2 → both issue together.
5. flushD asserted while in SECOND, with stallIn = 1 → issue 0, stall 0; next state PAIR (a following independent pair issues both).
6. Force 2^CNT_W + 3 consecutive load-use stalls → loadUseCount = 0xFFFF (CNT_W = 16). Then assert rst low mid-SECOND → counters 0 and all outputs 0 asynchronously.

Source files
------------

// File: rtl/dual_issue_scheduler.sv
// rtl/dual_issue_scheduler.sv - dual-issue decode-to-EX issue controller
// Splits dependent pairs, blocks load-use hazards, counts splits and stalls.
module dual_issue_scheduler #(
    parameter int CNT_W     = 16,
    parameter int MEM_PORTS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid1,
    input  logic             valid2,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rt1,
    input  logic [4:0]       rd1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rt2,
    input  logic [4:0]       rd2,
    input  logic             useRs1,
    input  logic             useRt1,
    input  logic             useRs2,
    input  logic             useRt2,
    input  logic             regWrite1,
    input  logic             regWrite2,
    input  logic             mem1,
    input  logic             mem2,
    input  logic             memReadE1,
    input  logic             memReadE2,
    input  logic [4:0]       writeRegisterE1,
    input  logic [4:0]       writeRegisterE2,
    input  logic             stallIn,
    input  logic             flushD,
    output logic             issue1,
    output logic             issue2,
    output logic             stallF,
    output logic             stallD,
    output logic [CNT_W-1:0] splitCount,
    output logic [CNT_W-1:0] loadUseCount
);

    typedef enum logic {PAIR, SECOND} state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] split_cnt;
    logic [CNT_W-1:0] lu_cnt;
    logic             inc_split;
    logic             inc_lu;
    logic             ld_haz1;
    logic             ld_haz2;
    logic             raw;
    logic             waw;
    logic             mem_conf;
    logic             dep;

    // True when a non-zero register r is read through an enabled source port.
    function automatic logic reads_reg(input logic [4:0] r,
                                       input logic [4:0] a, input logic ua,
                                       input logic [4:0] b, input logic ub);
        return (r != 5'd0) && ((ua && (a == r)) || (ub && (b == r)));
    endfunction

    always_comb begin
        ld_haz1  = (memReadE1 && reads_reg(writeRegisterE1, rs1, useRs1, rt1, useRt1)) ||
                   (memReadE2 && reads_reg(writeRegisterE2, rs1, useRs1, rt1, useRt1));
        ld_haz2  = (memReadE1 && reads_reg(writeRegisterE1, rs2, useRs2, rt2, useRt2)) ||
                   (memReadE2 && reads_reg(writeRegisterE2, rs2, useRs2, rt2, useRt2));
        raw      = regWrite1 && reads_reg(rd1, rs2, useRs2, rt2, useRt2);
        waw      = regWrite1 && regWrite2 && (rd1 != 5'd0) && (rd1 == rd2);
        mem_conf = (MEM_PORTS == 1) && mem1 && mem2;
        dep      = valid1 && valid2 && (raw || waw || mem_conf);
    end

    always_comb begin
        issue1     = 1'b0;
        issue2     = 1'b0;
        stallF     = 1'b0;
        stallD     = 1'b0;
        inc_split  = 1'b0;
        inc_lu     = 1'b0;
        next_state = state;
        if (!rst) begin
            next_state = PAIR;
        end else if (flushD) begin
            next_state = PAIR;
        end else if (stallIn) begin
            stallF = 1'b1;
            stallD = 1'b1;
        end else if (state == PAIR) begin
            if ((valid1 && ld_haz1) || (!valid1 && valid2 && ld_haz2)) begin
                stallF = 1'b1;
                stallD = 1'b1;
                inc_lu = 1'b1;
            end else if (valid1 && valid2 && (dep || ld_haz2)) begin
                // Slot 1 goes now; slot 2 waits in the held decode register.
                issue1     = 1'b1;
                stallF     = 1'b1;
                stallD     = 1'b1;
                inc_split  = 1'b1;
                next_state = SECOND;
            end else begin
                issue1 = valid1;
                issue2 = valid2;
            end
        end else begin
            if (ld_haz2) begin
                stallF = 1'b1;
                stallD = 1'b1;
                inc_lu = 1'b1;
            end else begin
                issue2     = 1'b1;
                next_state = PAIR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= PAIR;
            split_cnt <= '0;
            lu_cnt    <= '0;
        end else begin
            state <= next_state;
            if (inc_split && (split_cnt != '1))
                split_cnt <= split_cnt + CNT_W'(1);
            if (inc_lu && (lu_cnt != '1))
                lu_cnt <= lu_cnt + CNT_W'(1);
        end
    end

    assign splitCount   = split_cnt;
    assign loadUseCount = lu_cnt;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb/tb_dual_issue_scheduler.sv - self-checking bench for dual_issue_scheduler
// Two instances (one and two memory ports) share stimulus and a reference model.
module tb_dual_issue_scheduler;

    typedef struct {
        logic       v1, v2;
        logic [4:0] rs1, rt1, rd1, rs2, rt2, rd2;
        logic       ur1, ut1, ur2, ut2, rw1, rw2, m1, m2, mr1, mr2;
        logic [4:0] w1, w2;
        logic       stall_in, flush;
    } in_t;

    typedef struct {
        in_t        x;
        logic [3:0] e;
    } tv_t;

    typedef struct {
        logic [3:0] o;
        bit         nsec;
        bit         sp;
        bit         lu;
    } mres_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    in_t  cur;

    logic        valid1, valid2, useRs1, useRt1, useRs2, useRt2;
    logic        regWrite1, regWrite2, mem1, mem2, memReadE1, memReadE2;
    logic        stallIn, flushD;
    logic [4:0]  rs1, rt1, rd1, rs2, rt2, rd2, writeRegisterE1, writeRegisterE2;
    logic        issue1, issue2, stallF, stallD;
    logic        issue1_b, issue2_b, stallF_b, stallD_b;
    logic [15:0] splitCount, loadUseCount, splitCount_b, loadUseCount_b;

    int tests = 0;
    int fails = 0;
    bit m_sec [2];
    int m_split [2];
    int m_lu [2];

    assign valid1 = cur.v1;  assign valid2 = cur.v2;
    assign rs1 = cur.rs1;    assign rt1 = cur.rt1;    assign rd1 = cur.rd1;
    assign rs2 = cur.rs2;    assign rt2 = cur.rt2;    assign rd2 = cur.rd2;
    assign useRs1 = cur.ur1; assign useRt1 = cur.ut1;
    assign useRs2 = cur.ur2; assign useRt2 = cur.ut2;
    assign regWrite1 = cur.rw1; assign regWrite2 = cur.rw2;
    assign mem1 = cur.m1;    assign mem2 = cur.m2;
    assign memReadE1 = cur.mr1; assign memReadE2 = cur.mr2;
    assign writeRegisterE1 = cur.w1; assign writeRegisterE2 = cur.w2;
    assign stallIn = cur.stall_in; assign flushD = cur.flush;

    dual_issue_scheduler #(.CNT_W(16), .MEM_PORTS(1)) dut (
        .clk(clk), .rst(rst), .valid1(valid1), .valid2(valid2),
        .rs1(rs1), .rt1(rt1), .rd1(rd1), .rs2(rs2), .rt2(rt2), .rd2(rd2),
        .useRs1(useRs1), .useRt1(useRt1), .useRs2(useRs2), .useRt2(useRt2),
        .regWrite1(regWrite1), .regWrite2(regWrite2), .mem1(mem1), .mem2(mem2),
        .memReadE1(memReadE1), .memReadE2(memReadE2),
        .writeRegisterE1(writeRegisterE1), .writeRegisterE2(writeRegisterE2),
        .stallIn(stallIn), .flushD(flushD),
        .issue1(issue1), .issue2(issue2), .stallF(stallF), .stallD(stallD),
        .splitCount(splitCount), .loadUseCount(loadUseCount)
    );

    dual_issue_scheduler #(.CNT_W(16), .MEM_PORTS(2)) dut2 (
        .clk(clk), .rst(rst), .valid1(valid1), .valid2(valid2),
        .rs1(rs1), .rt1(rt1), .rd1(rd1), .rs2(rs2), .rt2(rt2), .rd2(rd2),
        .useRs1(useRs1), .useRt1(useRt1), .useRs2(useRs2), .useRt2(useRt2),
        .regWrite1(regWrite1), .regWrite2(regWrite2), .mem1(mem1), .mem2(mem2),
        .memReadE1(memReadE1), .memReadE2(memReadE2),
        .writeRegisterE1(writeRegisterE1), .writeRegisterE2(writeRegisterE2),
        .stallIn(stallIn), .flushD(flushD),
        .issue1(issue1_b), .issue2(issue2_b), .stallF(stallF_b), .stallD(stallD_b),
        .splitCount(splitCount_b), .loadUseCount(loadUseCount_b)
    );

    always #5 clk = ~clk;

    function automatic in_t base();
        in_t x;
        x.v1 = 1; x.v2 = 1;
        x.rs1 = 1; x.rt1 = 2; x.rd1 = 5;
        x.rs2 = 3; x.rt2 = 4; x.rd2 = 6;
        x.ur1 = 1; x.ut1 = 1; x.ur2 = 1; x.ut2 = 1;
        x.rw1 = 1; x.rw2 = 1; x.m1 = 0; x.m2 = 0;
        x.mr1 = 0; x.mr2 = 0; x.w1 = 9; x.w2 = 9;
        x.stall_in = 0; x.flush = 0;
        return x;
    endfunction

    // Set-membership view: does a slot's list of read registers contain r?
    function automatic bit slot_reads(logic [4:0] r, logic [4:0] a, logic ua,
                                      logic [4:0] b, logic ub);
        logic [4:0] srcs [$];
        srcs = {};
        if (ua) srcs.push_back(a);
        if (ub) srcs.push_back(b);
        if (r == 0) return 0;
        foreach (srcs[i]) if (srcs[i] == r) return 1;
        return 0;
    endfunction

    function automatic mres_t model(int mp, bit sec, in_t x);
        mres_t r;
        bit ld1, ld2, dep;
        ld1 = (x.mr1 && slot_reads(x.w1, x.rs1, x.ur1, x.rt1, x.ut1)) ||
              (x.mr2 && slot_reads(x.w2, x.rs1, x.ur1, x.rt1, x.ut1));
        ld2 = (x.mr1 && slot_reads(x.w1, x.rs2, x.ur2, x.rt2, x.ut2)) ||
              (x.mr2 && slot_reads(x.w2, x.rs2, x.ur2, x.rt2, x.ut2));
        dep = x.v1 && x.v2 &&
              ((x.rw1 && slot_reads(x.rd1, x.rs2, x.ur2, x.rt2, x.ut2)) ||
               (x.rw1 && x.rw2 && x.rd1 != 0 && x.rd1 == x.rd2) ||
               (mp == 1 && x.m1 && x.m2));
        r.o = 4'b0000; r.nsec = sec; r.sp = 0; r.lu = 0;
        if (x.flush) r.nsec = 0;
        else if (x.stall_in) r.o = 4'b0011;
        else if (!sec) begin
            if ((x.v1 && ld1) || (!x.v1 && x.v2 && ld2)) begin
                r.o = 4'b0011; r.lu = 1;
            end else if (x.v1 && x.v2 && (dep || ld2)) begin
                r.o = 4'b1011; r.sp = 1; r.nsec = 1;
            end else r.o = {x.v1, x.v2, 2'b00};
        end else if (ld2) begin
            r.o = 4'b0011; r.lu = 1;
        end else begin
            r.o = 4'b0100; r.nsec = 0;
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sec[k] = 0; m_split[k] = 0; m_lu[k] = 0;
        end
    endtask

    // One clock: compare at negedge, advance model at posedge, return at posedge+1.
    task automatic step(input bit chk, input bit t1en, input logic [3:0] t1,
                        input bit t2en, input logic [3:0] t2, input string nm);
        mres_t r [2];
        @(negedge clk);
        for (int k = 0; k < 2; k++) r[k] = model(k + 1, m_sec[k], cur);
        if (chk) begin
            check({nm, "_out"}, {issue1, issue2, stallF, stallD}, r[0].o);
            check({nm, "_out2"}, {issue1_b, issue2_b, stallF_b, stallD_b}, r[1].o);
            check({nm, "_cnt"}, {splitCount, loadUseCount}, {m_split[0][15:0], m_lu[0][15:0]});
            check({nm, "_cnt2"}, {splitCount_b, loadUseCount_b}, {m_split[1][15:0], m_lu[1][15:0]});
        end
        if (t1en) check({nm, "_tab"}, {issue1, issue2, stallF, stallD}, t1);
        if (t2en) check({nm, "_tab2"}, {issue1_b, issue2_b, stallF_b, stallD_b}, t2);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_sec[k] = r[k].nsec;
            if (r[k].sp && m_split[k] < 65535) m_split[k]++;
            if (r[k].lu && m_lu[k] < 65535) m_lu[k]++;
        end
        #1;
    endtask

    task automatic flush_step();
        cur = base(); cur.flush = 1;
        step(1, 1, 4'b0000, 0, 4'b0, "flush");
    endtask

    tv_t tab [16];

    initial begin
        for (int i = 0; i < 16; i++) tab[i].x = base();
        tab[0].e = 4'b1100;
        tab[1].x.rs2 = 5;                                tab[1].e = 4'b1011;
        tab[2].x.rt2 = 5;                                tab[2].e = 4'b1011;
        tab[3].x.rd2 = 5;                                tab[3].e = 4'b1011;
        tab[4].x.rs2 = 5; tab[4].x.ur2 = 0;              tab[4].e = 4'b1100;
        tab[5].x.rd1 = 0; tab[5].x.rs2 = 0; tab[5].x.rd2 = 0; tab[5].e = 4'b1100;
        tab[6].x.m1 = 1; tab[6].x.m2 = 1;                tab[6].e = 4'b1011;
        tab[7].x.mr2 = 1; tab[7].x.w2 = 2;               tab[7].e = 4'b0011;
        tab[8].x.mr1 = 1; tab[8].x.w1 = 4;               tab[8].e = 4'b1011;
        tab[9].x.v1 = 0; tab[9].x.mr1 = 1; tab[9].x.w1 = 4; tab[9].e = 4'b0011;
        tab[10].x.v2 = 0;                                tab[10].e = 4'b1000;
        tab[11].x.stall_in = 1;                          tab[11].e = 4'b0011;
        tab[12].x.stall_in = 1; tab[12].x.flush = 1;     tab[12].e = 4'b0000;
        tab[13].x.v1 = 0; tab[13].x.v2 = 0;              tab[13].e = 4'b0000;
        tab[14].x.rs1 = 0; tab[14].x.mr1 = 1; tab[14].x.w1 = 0; tab[14].e = 4'b1100;
        tab[15].x.v1 = 0;                                tab[15].e = 4'b0100;

        // Reset state: outputs forced low even with an issuable pair present.
        cur = base();
        #3;
        check("reset_out", {issue1, issue2, stallF, stallD}, 4'b0000);
        check("reset_cnt", {splitCount, loadUseCount}, 32'h0);
        @(posedge clk); #1;
        rst = 1;
        model_reset();

        cur = base();
        step(1, 1, 4'b1100, 1, 4'b1100, "indep");
        check("indep_cnt0", {splitCount, loadUseCount}, 32'h0);

        cur = base(); cur.rs2 = 5;
        step(1, 1, 4'b1011, 1, 4'b1011, "raw_c0");
        step(1, 1, 4'b0100, 1, 4'b0100, "raw_c1");
        check("raw_split1", splitCount, 16'd1);

        cur = base(); cur.rt1 = 7; cur.mr2 = 1; cur.w2 = 7;
        step(1, 1, 4'b0011, 1, 4'b0011, "lu_c0");
        check("lu_count1", loadUseCount, 16'd1);
        cur.mr2 = 0;
        step(1, 1, 4'b1100, 1, 4'b1100, "lu_c1");

        cur = base(); cur.m1 = 1; cur.m2 = 1;
        step(1, 1, 4'b1011, 1, 4'b1100, "mem_c0");
        step(1, 1, 4'b0100, 1, 4'b1100, "mem_c1");

        for (int i = 0; i < 16; i++) begin
            cur = tab[i].x;
            step(1, 1, tab[i].e, 0, 4'b0, $sformatf("vec%0d", i));
            flush_step();
        end

        // Flush while in SECOND beats a simultaneous stall request.
        cur = base(); cur.rs2 = 5;
        step(1, 1, 4'b1011, 0, 4'b0, "fl_split");
        cur.flush = 1; cur.stall_in = 1;
        step(1, 1, 4'b0000, 0, 4'b0, "fl_second");
        cur = base();
        step(1, 1, 4'b1100, 0, 4'b0, "fl_after");

        for (int i = 0; i < 1500; i++) begin
            cur.v1 = ($urandom_range(0, 3) != 0);
            cur.v2 = ($urandom_range(0, 3) != 0);
            cur.rs1 = 5'($urandom_range(0, 7)); cur.rt1 = 5'($urandom_range(0, 7));
            cur.rd1 = 5'($urandom_range(0, 7)); cur.rs2 = 5'($urandom_range(0, 7));
            cur.rt2 = 5'($urandom_range(0, 7)); cur.rd2 = 5'($urandom_range(0, 7));
            cur.ur1 = 1'($urandom); cur.ut1 = 1'($urandom);
            cur.ur2 = 1'($urandom); cur.ut2 = 1'($urandom);
            cur.rw1 = 1'($urandom); cur.rw2 = 1'($urandom);
            cur.m1 = ($urandom_range(0, 3) == 0); cur.m2 = ($urandom_range(0, 3) == 0);
            cur.mr1 = ($urandom_range(0, 3) == 0); cur.mr2 = ($urandom_range(0, 3) == 0);
            cur.w1 = 5'($urandom_range(0, 7)); cur.w2 = 5'($urandom_range(0, 7));
            cur.stall_in = ($urandom_range(0, 7) == 0);
            cur.flush = ($urandom_range(0, 15) == 0);
            step(1, 0, 4'b0, 0, 4'b0, "rand");
        end

        // Saturate the load-use counter with 2^16 + 3 consecutive stalls.
        flush_step();
        cur = base(); cur.mr1 = 1; cur.w1 = 1;
        for (int i = 0; i < 65539; i++) step(0, 0, 4'b0, 0, 4'b0, "sat");
        step(1, 1, 4'b0011, 1, 4'b0011, "sat_end");
        check("sat_lu", loadUseCount, 16'hFFFF);

        // Asynchronous reset mid-SECOND drops slot 2 immediately.
        cur = base(); cur.rs2 = 5;
        step(1, 1, 4'b1011, 0, 4'b0, "ar_split");
        @(negedge clk); #2;
        rst = 0;
        #1;
        check("ar_out", {issue1, issue2, stallF, stallD}, 4'b0000);
        check("ar_cnt", {splitCount, loadUseCount}, 32'h0);
        check("ar_cnt2", {splitCount_b, loadUseCount_b}, 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst = 1;
        cur = base();
        step(1, 1, 4'b1100, 1, 4'b1100, "ar_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
